// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Centisecond stopwatch source for the six-digit seven-segment display path.
// Two raw buttons (start/stop, clear) are synchronized and debounced. A
// three-state FSM (IDLE / RUN / PAUSE) gates a prescaler. The prescaler
// produces one tick every TICK_CYCLES clocks, and each tick advances a binary
// count that wraps from COUNT_MAX to 0. Every newly written count is announced
// with a one-cycle number_en strobe. The display driver latches number on
// that strobe.
//
// Parameters:
//   TICK_CYCLES  clk cycles per count increment (>= 64)
//   DEB_CYCLES   consecutive stable cycles needed to accept a button change (>= 2)
//   COUNT_MAX    last count value before wrap (< 2^20)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   btn_ss     in   raw start/stop button, active-high, asynchronous
//   btn_clr    in   raw clear button, active-high, asynchronous
//   number     out  current count (binary, 20 bits)
//   number_en  out  one-cycle strobe: number was just written
//   running    out  high while the FSM is in RUN
//   overflow   out  sticky wrap flag, cleared by clear or reset
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter int unsigned DEB_CYCLES  = 2_000_000,
  parameter int unsigned COUNT_MAX   = 999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [19:0] number,
  output logic        number_en,
  output logic        running,
  output logic        overflow
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DW = $clog2(DEB_CYCLES);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [19:0]   COUNT_LAST = 20'(COUNT_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  // Bit 0 = start/stop, bit 1 = clear.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_clr, btn_ss};

  // ---------------------------------------------------------------------------
  // Per-button synchronizer + debouncer + rising-edge press pulse.
  // The debounce counter only runs while the synchronized level disagrees with
  // the accepted (stable) level. Any agreeing cycle restarts it, so a change
  // must persist for DEB_CYCLES consecutive cycles before it is accepted.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          press_reg;
      logic [DW-1:0] deb_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          stable_reg  <= 1'b0;
          press_reg   <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg != stable_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
              stable_reg  <= sync2_reg;
              deb_cnt_reg <= '0;
              // Pulse only when the accepted level rises; a release is silent.
              press_reg   <= sync2_reg;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
          end else begin
            deb_cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic press_ss;
  logic press_clr;

  assign press_ss  = press[0];
  assign press_clr = press[1];

  // ---------------------------------------------------------------------------
  // Control FSM. Clear has priority over start/stop from every state.
  // ---------------------------------------------------------------------------
  logic [1:0] state_reg;
  logic [1:0] state_next;

  always_comb begin
    state_next = state_reg;
    if (press_clr) begin
      state_next = IDLE;
    end else if (press_ss) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, count, overflow and strobe.
  // The prescaler advances only while RUN and simply holds in PAUSE. A resume
  // therefore finishes the partial interval instead of starting a fresh one.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic [19:0]   count_reg;
  logic          overflow_reg;
  logic          number_en_reg;
  logic          running_reg;
  logic          tick;

  assign tick = (state_reg == RUN) && (presc_reg == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      running_reg   <= 1'b0;
      presc_reg     <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      number_en_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      running_reg   <= (state_next == RUN);
      number_en_reg <= 1'b0;
      if (press_clr) begin
        // A clear always rewrites number, even if it is already 0. That is why
        // it strobes, and why a coincident tick is swallowed into one strobe.
        presc_reg     <= '0;
        count_reg     <= '0;
        overflow_reg  <= 1'b0;
        number_en_reg <= 1'b1;
      end else begin
        if (state_reg == RUN) begin
          presc_reg <= tick ? '0 : presc_reg + 1'b1;
        end
        if (tick) begin
          number_en_reg <= 1'b1;
          if (count_reg == COUNT_LAST) begin
            count_reg    <= '0;
            overflow_reg <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      end
    end
  end

  assign number    = count_reg;
  assign number_en = number_en_reg;
  assign running   = running_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Directed bench for stopwatch_counter with TICK_CYCLES=100, DEB_CYCLES=8 and
// COUNT_MAX=15. The main run is a table of timed checkpoints. Each record
// holds the button levels to drive from that point on, plus the outputs
// expected there. The times are hand-derived: a button set just after edge T
// changes the state at edge T+11, and ticks follow every 100 RUN cycles.
// Hand-written sequences cover debounce glitches, simultaneous presses and
// reset during activity.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

  logic        clk;
  logic        rst;
  logic        btn_ss;
  logic        btn_clr;
  logic [19:0] number;
  logic        number_en;
  logic        running;
  logic        overflow;

  stopwatch_counter #(
    .TICK_CYCLES(100),
    .DEB_CYCLES (8),
    .COUNT_MAX  (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_clr  (btn_clr),
    .number   (number),
    .number_en(number_en),
    .running  (running),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  int strobes  = 0;
  int b2b      = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (number_en === 1'b1) strobes = strobes + 1;
    if (prev_en === 1'b1 && number_en === 1'b1) b2b = b2b + 1;
    prev_en = number_en;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) step(1);
  endtask

  // which: 0 = start/stop, 1 = clear, 2 = both in the same cycle
  task automatic press(input int which, input int hold);
    if (which != 1) btn_ss = 1'b1;
    if (which != 0) btn_clr = 1'b1;
    step(hold);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [19:0] n, input logic en,
                               input logic run, input logic ovf);
    check({tag, " number"},    32'(number),    32'(n));
    check({tag, " number_en"}, 32'(number_en), 32'(en));
    check({tag, " running"},   32'(running),   32'(run));
    check({tag, " overflow"},  32'(overflow),  32'(ovf));
  endtask

  typedef struct {
    int          at;
    logic        ss;
    logic        clr;
    logic [19:0] num;
    logic        en;
    logic        run;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int at, input logic ss, input logic clr, input logic [19:0] num,
                     input logic en, input logic run, input logic ovf);
    vec_t v;
    v.at = at; v.ss = ss; v.clr = clr; v.num = num; v.en = en; v.run = run; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int s0;

    // at, ss, clr, number, en, running, overflow
    add(   0, 1, 0,  0, 0, 0, 0);  // start press begins
    add(  10, 1, 0,  0, 0, 0, 0);  // one cycle before RUN
    add(  11, 1, 0,  0, 0, 1, 0);  // RUN entered
    add(  20, 0, 0,  0, 0, 1, 0);
    add( 110, 0, 0,  0, 0, 1, 0);  // one cycle before first tick
    add( 111, 0, 0,  1, 1, 1, 0);  // first tick
    add( 112, 0, 0,  1, 0, 1, 0);
    add( 211, 0, 0,  2, 1, 1, 0);
    add( 250, 1, 0,  2, 0, 1, 0);  // pause press, 50 cycles into interval
    add( 260, 1, 0,  2, 0, 1, 0);
    add( 261, 1, 0,  2, 0, 0, 0);  // PAUSE, prescaler held at 50
    add( 270, 0, 0,  2, 0, 0, 0);
    add( 311, 0, 0,  2, 0, 0, 0);  // would have ticked if still running
    add( 400, 1, 0,  2, 0, 0, 0);  // resume press
    add( 410, 1, 0,  2, 0, 0, 0);
    add( 411, 1, 0,  2, 0, 1, 0);  // RUN again
    add( 420, 0, 0,  2, 0, 1, 0);
    add( 460, 0, 0,  2, 0, 1, 0);
    add( 461, 0, 0,  3, 1, 1, 0);  // only the remaining 50 cycles
    add( 561, 0, 0,  4, 1, 1, 0);
    add(1661, 0, 0, 15, 1, 1, 0);
    add(1760, 0, 0, 15, 0, 1, 0);
    add(1761, 0, 0,  0, 1, 1, 1);  // wrap
    add(1762, 0, 0,  0, 0, 1, 1);
    add(1861, 0, 0,  1, 1, 1, 1);  // overflow is sticky
    add(1950, 0, 1,  1, 0, 1, 1);  // clear press, lands on a tick edge
    add(1960, 0, 1,  1, 0, 1, 1);
    add(1961, 0, 1,  0, 1, 0, 0);  // clear beats coincident tick
    add(1962, 0, 1,  0, 0, 0, 0);  // still a single strobe
    add(1970, 0, 0,  0, 0, 0, 0);
    add(2000, 0, 0,  0, 0, 0, 0);

    // ---------------- Reset ----------------
    rst = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0;
    step(3);
    rst = 1'b0;
    check_outputs("reset", 20'd0, 1'b0, 1'b0, 1'b0);
    s0 = strobes;
    step(500);
    check("idle strobes", 32'(strobes - s0), 32'd0);
    check("idle running", 32'(running), 32'd0);

    // ---------------- Table-driven main run ----------------
    base = cyc;
    s0   = strobes;
    foreach (vecs[i]) begin
      goto_cyc(base + vecs[i].at);
      $display("[TB] vec %0d t=%0d ss=%0b clr=%0b number=%0d en=%0b running=%0b overflow=%0b",
               i, vecs[i].at, btn_ss, btn_clr, number, number_en, running, overflow);
      check_outputs($sformatf("vec%0d", i), vecs[i].num, vecs[i].en, vecs[i].run, vecs[i].ovf);
      btn_ss  = vecs[i].ss;
      btn_clr = vecs[i].clr;
    end
    check("table strobes", 32'(strobes - s0), 32'd18);

    // ---------------- Debounce ----------------
    s0 = strobes;
    btn_ss = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(3);
      btn_ss = ~btn_ss;
    end
    btn_ss = 1'b0;
    step(30);
    $display("[TB] debounce toggle: running=%0b", running);
    check("toggle running", 32'(running), 32'd0);
    press(0, 7);
    step(30);
    $display("[TB] debounce hold7: running=%0b", running);
    check("hold7 running", 32'(running), 32'd0);
    check("glitch strobes", 32'(strobes - s0), 32'd0);

    btn_ss = 1'b1;
    step(9);
    btn_ss = 1'b0;
    step(1);
    check("hold9 pre running", 32'(running), 32'd0);
    step(1);
    $display("[TB] debounce hold9: running=%0b", running);
    check("hold9 running", 32'(running), 32'd1);
    step(150);
    check("hold9 number", 32'(number), 32'd1);
    check("hold9 single press", 32'(running), 32'd1);

    // ---------------- Simultaneous press in PAUSE ----------------
    press(0, 20);
    check("pause running", 32'(running), 32'd0);
    check("pause number", 32'(number), 32'd1);
    s0 = strobes;
    press(2, 20);
    step(20);
    $display("[TB] both buttons: number=%0d running=%0b overflow=%0b", number, running, overflow);
    check("both running", 32'(running), 32'd0);
    check("both number", 32'(number), 32'd0);
    check("both overflow", 32'(overflow), 32'd0);
    check("both strobes", 32'(strobes - s0), 32'd1);

    // ---------------- Reset mid-debounce ----------------
    btn_ss = 1'b1;
    step(7);  // debounce counter now at 5
    rst = 1'b1;
    btn_ss = 1'b0;
    step(1);
    rst = 1'b0;
    s0 = strobes;
    check_outputs("rst mid-deb", 20'd0, 1'b0, 1'b0, 1'b0);
    step(40);
    $display("[TB] reset mid-debounce: running=%0b strobes=%0d", running, strobes - s0);
    check("rst mid-deb running", 32'(running), 32'd0);
    check("rst mid-deb strobes", 32'(strobes - s0), 32'd0);

    // ---------------- Reset mid-RUN ----------------
    press(0, 20);
    step(150);
    check("pre-rst number", 32'(number), 32'd1);
    check("pre-rst running", 32'(running), 32'd1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check_outputs("rst mid-run", 20'd0, 1'b0, 1'b0, 1'b0);
    s0 = strobes;
    step(200);
    $display("[TB] reset mid-run: number=%0d running=%0b strobes=%0d", number, running, strobes - s0);
    check("post-rst strobes", 32'(strobes - s0), 32'd0);
    check("post-rst running", 32'(running), 32'd0);
    check("post-rst number", 32'(number), 32'd0);

    check("back-to-back strobes", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
